exec_controller: RTL and testbench
==================================

# exec_controller

Execution sequencer for the 5-stage MIPS pipeline. It sits between the debug/UART front end and the pipeline registers, and owns the global enables: PC enable, IF/ID enable, pipeline-register enable and the flush lines. It supports continuous run, single-step, load-use stall insertion, taken-branch squash, and a fixed pipeline drain after HALT is decoded. It also maintains cycle and retired-fetch counters for the debug unit.

## Interface
- NB_CNT, 32, width of cycle and fetch counters
- DRAIN_CYCLES, 4, cycles the pipeline keeps clocking after HALT leaves ID (ID→EX→MEM→WB)
- clk  in  1  system clock
- i_rst  in  1  synchronous, active-high reset
- i_start  in  1  one-cycle pulse; leaves IDLE
- i_mode  in  1  0 = continuous, 1 = step; sampled only on accepted i_start
- i_step  in  1  one-cycle pulse; advances one cycle in step mode
- i_clear  in  1  pulse; DONE → IDLE
- i_halt_id  in  1  HALT opcode (6'b111111) present in ID
- i_load_stall  in  1  load-use hazard detected in ID
- i_branch_taken  in  1  branch/jump resolved taken in ID
- o_pc_en  out  1  PC register enable
- o_if_id_en  out  1  IF/ID register enable
- o_pipe_en  out  1  enable for ID/EX, EX/MEM, MEM/WB
- o_if_id_flush  out  1  load NOP into IF/ID
- o_id_ex_flush  out  1  load bubble into ID/EX
- o_busy  out  1  state ∉ {IDLE, DONE}
- o_done  out  1  state == DONE
- o_state  out  3  current state encoding
- o_cycle_cnt  out  NB_CNT  cycles with o_pipe_en = 1
- o_fetch_cnt  out  NB_CNT  cycles with o_pc_en = 1

## Operation
- States: IDLE=0, RUN=1, STEP_WAIT=2, STEP_EXEC=3, DRAIN=4, DONE=5. Codes 6 and 7 are unreachable and go to IDLE.
- IDLE: all enables and flushes are 0. On i_start, clear both counters and go to RUN if i_mode = 0, or to STEP_WAIT if i_mode = 1.
- RUN and STEP_EXEC are the "active cycle" states:
  - Default outputs: o_pipe_en = 1, o_pc_en = 1, o_if_id_en = 1.
  - If i_load_stall: o_pc_en = 0, o_if_id_en = 0, o_id_ex_flush = 1. i_branch_taken and i_halt_id are ignored that cycle.
  - Else if i_halt_id: o_pc_en = 0, o_if_id_flush = 1, load drain counter with DRAIN_CYCLES, and go to DRAIN.
  - Else if i_branch_taken: o_if_id_flush = 1 (squash the fetched successor).
  - STEP_EXEC always leaves after one cycle: to STEP_WAIT, or to DRAIN on halt.
- STEP_WAIT: all enables are 0. i_step → STEP_EXEC.
- DRAIN: o_pipe_en = 1, o_pc_en = 0, o_if_id_en = 1, o_if_id_flush = 1. The counter decrements each cycle. When the counter == 1, go to DONE. Drain is automatic in both modes.
- DONE: all enables are 0 and o_done = 1. i_clear → IDLE. i_start is ignored.
- Counters:
  - Increment on o_pipe_en and o_pc_en respectively.
  - Saturate at 2^NB_CNT−1.
  - Hold their value in DONE and IDLE until the next accepted i_start.
- Enables and flushes are combinational from the registered state and the same-cycle inputs. The state and counters are registered.

## Timing
- Reset: state = IDLE, all enable and flush outputs = 0, o_busy = 0, o_done = 0, counters = 0, drain counter = 0. Reset wins over every other input in the same cycle; a reset mid-RUN or mid-DRAIN returns to IDLE on the next edge.
- i_start at edge t: state is RUN at t+1, and o_pc_en can be 1 from t+1.
- A HALT in ID at cycle h: o_pc_en = 0 from h. DRAIN covers h+1 … h+DRAIN_CYCLES. o_done = 1 from h+DRAIN_CYCLES+1.
- Step: i_step at t gives exactly one active cycle at t+1, then STEP_WAIT at t+2.
  - i_step during STEP_EXEC, DRAIN, RUN or IDLE is ignored (no queuing).
  - An i_step coincident with an accepted i_start is ignored.
- A stall holds for as many cycles as i_load_stall stays high. Each stalled cycle still counts in o_cycle_cnt but not in o_fetch_cnt.
- i_clear and i_start asserted together in DONE: go to IDLE, and the start is dropped.

## Structure
- Shared package `exec_ctrl_pkg` holds:
  - state localparams (3-bit)
  - HALT_OPCODE = 6'b111111
  - default DRAIN_CYCLES
- Sub-module `sat_counter`, parameterised NB_CNT, with inputs clear and inc; instantiated twice.
- The FSM and output decode live in `exec_controller`.

## Test plan
- Continuous run: start with mode 0, 10 free cycles, then i_halt_id → o_pc_en drops at the halt cycle, o_done rises 5 cycles later, o_cycle_cnt = 10+1+4 = 15, o_fetch_cnt = 10.
- Load-use: i_load_stall high for 1 cycle together with i_branch_taken in RUN → o_pc_en = 0, o_if_id_en = 0, o_id_ex_flush = 1, o_if_id_flush = 0; o_fetch_cnt is one less than o_cycle_cnt.
- Branch: i_branch_taken alone → o_if_id_flush = 1 for one cycle, with o_pc_en still 1.
- Step mode: start with mode 1, three i_step pulses spaced 4 cycles apart plus an extra i_step during STEP_EXEC → exactly 3 active cycles, o_cycle_cnt = 3, state returns to 2 after each.
- Reset mid-DRAIN: assert i_rst at DRAIN cycle 2 → IDLE next cycle, all outputs 0; a new start then works normally.
- DONE handling: i_start in DONE → no effect; i_clear → o_state = 0, and the counters keep 15 until the next start clears them.

Source files
------------

// File: rtl/exec_ctrl_pkg.sv
// Shared definitions for the pipeline execution sequencer: state codes,
// the HALT opcode and the default drain length.
package exec_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_RUN       = 3'd1,
    ST_STEP_WAIT = 3'd2,
    ST_STEP_EXEC = 3'd3,
    ST_DRAIN     = 3'd4,
    ST_DONE      = 3'd5
  } state_t;

  localparam int         STATE_W              = 3;
  localparam logic [5:0] HALT_OPCODE          = 6'b111111;
  localparam int         DEFAULT_DRAIN_CYCLES = 4;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
  parameter int NB_CNT = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              inc,
  output logic [NB_CNT-1:0] count
);

  logic [NB_CNT-1:0] count_reg;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count_reg <= '0;
    end else if (inc && (count_reg != '1)) begin
      count_reg <= count_reg + NB_CNT'(1);
    end
  end

  assign count = count_reg;

endmodule

// File: rtl/exec_controller.sv
// Execution sequencer for the 5-stage pipeline: owns PC/IF-ID/pipe enables,
// flush lines, run/step/drain sequencing and the cycle/fetch counters.
module exec_controller
  import exec_ctrl_pkg::*;
#(
  parameter int NB_CNT       = 32,
  parameter int DRAIN_CYCLES = DEFAULT_DRAIN_CYCLES
) (
  input  logic               clk,
  input  logic               i_rst,
  input  logic               i_start,
  input  logic               i_mode,
  input  logic               i_step,
  input  logic               i_clear,
  input  logic               i_halt_id,
  input  logic               i_load_stall,
  input  logic               i_branch_taken,
  output logic               o_pc_en,
  output logic               o_if_id_en,
  output logic               o_pipe_en,
  output logic               o_if_id_flush,
  output logic               o_id_ex_flush,
  output logic               o_busy,
  output logic               o_done,
  output logic [STATE_W-1:0] o_state,
  output logic [NB_CNT-1:0]  o_cycle_cnt,
  output logic [NB_CNT-1:0]  o_fetch_cnt
);

  localparam int DRAIN_W = $clog2(DRAIN_CYCLES + 1);

  state_t             state_reg, state_next;
  logic [DRAIN_W-1:0] drain_reg, drain_next;
  logic               cnt_clear;

  always_ff @(posedge clk) begin
    if (i_rst) begin
      state_reg <= ST_IDLE;
      drain_reg <= '0;
    end else begin
      state_reg <= state_next;
      drain_reg <= drain_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    drain_next    = drain_reg;
    cnt_clear     = 1'b0;
    o_pc_en       = 1'b0;
    o_if_id_en    = 1'b0;
    o_pipe_en     = 1'b0;
    o_if_id_flush = 1'b0;
    o_id_ex_flush = 1'b0;
    o_done        = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (i_start) begin
          cnt_clear  = 1'b1;
          state_next = i_mode ? ST_STEP_WAIT : ST_RUN;
        end
      end
      ST_RUN, ST_STEP_EXEC: begin
        o_pipe_en  = 1'b1;
        o_pc_en    = 1'b1;
        o_if_id_en = 1'b1;
        if (state_reg == ST_STEP_EXEC) begin
          state_next = ST_STEP_WAIT;
        end
        // A load-use stall masks any branch or halt seen in the same cycle.
        if (i_load_stall) begin
          o_pc_en       = 1'b0;
          o_if_id_en    = 1'b0;
          o_id_ex_flush = 1'b1;
        end else if (i_halt_id) begin
          o_pc_en       = 1'b0;
          o_if_id_flush = 1'b1;
          drain_next    = DRAIN_W'(DRAIN_CYCLES);
          state_next    = ST_DRAIN;
        end else if (i_branch_taken) begin
          o_if_id_flush = 1'b1;
        end
      end
      ST_STEP_WAIT: begin
        if (i_step) begin
          state_next = ST_STEP_EXEC;
        end
      end
      ST_DRAIN: begin
        o_pipe_en     = 1'b1;
        o_if_id_en    = 1'b1;
        o_if_id_flush = 1'b1;
        drain_next    = drain_reg - DRAIN_W'(1);
        if (drain_reg <= DRAIN_W'(1)) begin
          drain_next = '0;
          state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        o_done = 1'b1;
        if (i_clear) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign o_busy  = (state_reg != ST_IDLE) && (state_reg != ST_DONE);
  assign o_state = state_reg;

  // Index 0 counts pipeline cycles, index 1 counts fetches.
  logic [1:0]        cnt_inc;
  logic [NB_CNT-1:0] cnt_val [2];

  assign cnt_inc = {o_pc_en, o_pipe_en};

  for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
    sat_counter #(
      .NB_CNT(NB_CNT)
    ) u_cnt (
      .clk  (clk),
      .rst  (i_rst),
      .clear(cnt_clear),
      .inc  (cnt_inc[gi]),
      .count(cnt_val[gi])
    );
  end

  assign o_cycle_cnt = cnt_val[0];
  assign o_fetch_cnt = cnt_val[1];

endmodule

// File: tb/tb_exec_controller.sv
// Scoreboard bench for exec_controller: stimulus queues per-cycle expectations,
// a negedge monitor pops and compares them against the live outputs.
module tb_exec_controller;
  import exec_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        i_rst, i_start, i_mode, i_step, i_clear;
  logic        i_halt_id, i_load_stall, i_branch_taken;
  logic        o_pc_en, o_if_id_en, o_pipe_en, o_if_id_flush, o_id_ex_flush;
  logic        o_busy, o_done;
  logic [2:0]  o_state;
  logic [31:0] o_cycle_cnt, o_fetch_cnt;

  always #5 clk = ~clk;

  exec_controller #(
    .NB_CNT(32),
    .DRAIN_CYCLES(4)
  ) dut (
    .clk(clk), .i_rst(i_rst), .i_start(i_start), .i_mode(i_mode),
    .i_step(i_step), .i_clear(i_clear), .i_halt_id(i_halt_id),
    .i_load_stall(i_load_stall), .i_branch_taken(i_branch_taken),
    .o_pc_en(o_pc_en), .o_if_id_en(o_if_id_en), .o_pipe_en(o_pipe_en),
    .o_if_id_flush(o_if_id_flush), .o_id_ex_flush(o_id_ex_flush),
    .o_busy(o_busy), .o_done(o_done), .o_state(o_state),
    .o_cycle_cnt(o_cycle_cnt), .o_fetch_cnt(o_fetch_cnt)
  );

  typedef enum int {S_PC, S_IFID, S_PIPE, S_IFF, S_IDF, S_BUSY, S_DONE,
                    S_STATE, S_CCNT, S_FCNT} sig_t;
  typedef struct {
    int          cyc;
    sig_t        sel;
    logic [31:0] exp;
    string       name;
  } exp_t;

  exp_t sb_q[$];
  int   cyc     = 0;
  int   n_total = 0;
  int   n_pass  = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] probe(input sig_t s);
    case (s)
      S_PC:    return {31'b0, o_pc_en};
      S_IFID:  return {31'b0, o_if_id_en};
      S_PIPE:  return {31'b0, o_pipe_en};
      S_IFF:   return {31'b0, o_if_id_flush};
      S_IDF:   return {31'b0, o_id_ex_flush};
      S_BUSY:  return {31'b0, o_busy};
      S_DONE:  return {31'b0, o_done};
      S_STATE: return {29'b0, o_state};
      S_CCNT:  return o_cycle_cnt;
      default: return o_fetch_cnt;
    endcase
  endfunction

  // Monitor: compare every expectation queued for the current cycle.
  always @(negedge clk) begin
    exp_t e;
    logic [31:0] got;
    while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
      e = sb_q.pop_front();
      n_total++;
      got = probe(e.sel);
      if (e.cyc != cyc)
        $display("FAIL %s: expectation for cycle %0d seen at cycle %0d", e.name, e.cyc, cyc);
      else if (got !== e.exp)
        $display("FAIL %s @cyc %0d: got %0d expected %0d", e.name, cyc, got, e.exp);
      else begin
        n_pass++;
        $display("check %s @cyc %0d: %0d ok", e.name, cyc, got);
      end
    end
  end

  task automatic chk(input sig_t sel, input logic [31:0] v, input string nm);
    exp_t e;
    e.cyc  = cyc;
    e.sel  = sel;
    e.exp  = v;
    e.name = nm;
    sb_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    i_rst = 1'b1; i_start = 1'b0; i_mode = 1'b0; i_step = 1'b0; i_clear = 1'b0;
    i_halt_id = 1'b0; i_load_stall = 1'b0; i_branch_taken = 1'b0;
    tick(); tick();
    i_rst = 1'b0;
    chk(S_STATE, 0, "rst_state"); chk(S_PC, 0, "rst_pc_en"); chk(S_PIPE, 0, "rst_pipe_en");
    chk(S_IFF, 0, "rst_if_id_flush"); chk(S_BUSY, 0, "rst_busy"); chk(S_DONE, 0, "rst_done");
    chk(S_CCNT, 0, "rst_cycle_cnt"); chk(S_FCNT, 0, "rst_fetch_cnt");

    // Continuous run: 10 free cycles, halt, 4 drain cycles
    i_start = 1'b1; i_mode = 1'b0;
    tick(); i_start = 1'b0;
    chk(S_STATE, 1, "run_state"); chk(S_PC, 1, "run_pc_en"); chk(S_CCNT, 0, "run_cnt_cleared");
    for (int i = 1; i < 10; i++) begin
      tick();
      if (i == 1) chk(S_CCNT, 1, "run_cycle_cnt_c2");
    end
    chk(S_CCNT, 9, "run_cycle_cnt_c10"); chk(S_FCNT, 9, "run_fetch_cnt_c10");
    tick(); i_halt_id = 1'b1;
    chk(S_PC, 0, "halt_pc_en"); chk(S_IFF, 1, "halt_if_id_flush");
    chk(S_PIPE, 1, "halt_pipe_en"); chk(S_IFID, 1, "halt_if_id_en");
    tick(); i_halt_id = 1'b0;
    chk(S_STATE, 4, "drain_state"); chk(S_PC, 0, "drain_pc_en"); chk(S_IFF, 1, "drain_flush");
    chk(S_PIPE, 1, "drain_pipe_en"); chk(S_BUSY, 1, "drain_busy");
    tick(); tick(); tick();
    chk(S_STATE, 4, "drain_last_state"); chk(S_DONE, 0, "drain_last_done");
    tick();
    chk(S_DONE, 1, "done_flag"); chk(S_STATE, 5, "done_state"); chk(S_BUSY, 0, "done_busy");
    chk(S_PIPE, 0, "done_pipe_en"); chk(S_CCNT, 15, "done_cycle_cnt"); chk(S_FCNT, 10, "done_fetch_cnt");

    // DONE: start ignored; clear+start returns to IDLE with counters held
    i_start = 1'b1;
    tick(); i_start = 1'b0;
    chk(S_STATE, 5, "done_start_ignored"); chk(S_CCNT, 15, "done_cnt_hold");
    i_clear = 1'b1; i_start = 1'b1;
    tick(); i_clear = 1'b0; i_start = 1'b0;
    chk(S_STATE, 0, "clear_state"); chk(S_CCNT, 15, "idle_cycle_hold"); chk(S_FCNT, 10, "idle_fetch_hold");

    // Load-use stall with branch, branch alone, stall masking halt
    i_start = 1'b1;
    tick(); i_start = 1'b0;
    chk(S_CCNT, 0, "restart_cnt_cleared");
    i_load_stall = 1'b1; i_branch_taken = 1'b1;
    chk(S_PC, 0, "stall_pc_en"); chk(S_IFID, 0, "stall_if_id_en"); chk(S_IDF, 1, "stall_id_ex_flush");
    chk(S_IFF, 0, "stall_if_id_flush"); chk(S_PIPE, 1, "stall_pipe_en");
    tick(); i_load_stall = 1'b0;
    chk(S_IFF, 1, "branch_if_id_flush"); chk(S_PC, 1, "branch_pc_en"); chk(S_IDF, 0, "branch_id_ex_flush");
    tick(); i_branch_taken = 1'b0; i_load_stall = 1'b1; i_halt_id = 1'b1;
    chk(S_CCNT, 2, "stall_cycle_cnt"); chk(S_FCNT, 1, "stall_fetch_cnt"); chk(S_IFF, 0, "stall_masks_halt");
    tick(); i_load_stall = 1'b0; i_step = 1'b1;
    chk(S_STATE, 1, "stall_halt_stays_run"); chk(S_CCNT, 3, "stall2_cycle_cnt"); chk(S_PC, 0, "halt2_pc_en");
    tick(); i_halt_id = 1'b0; i_step = 1'b0;
    chk(S_STATE, 4, "halt2_drain_state");
    tick(); tick(); tick(); tick();
    chk(S_DONE, 1, "done2_flag"); chk(S_CCNT, 8, "done2_cycle_cnt"); chk(S_FCNT, 1, "done2_fetch_cnt");
    i_clear = 1'b1;
    tick(); i_clear = 1'b0;
    chk(S_STATE, 0, "clear2_state");

    // Step mode: step coincident with start ignored; 3 steps, one extra during STEP_EXEC
    i_start = 1'b1; i_mode = 1'b1; i_step = 1'b1;
    tick(); i_start = 1'b0; i_step = 1'b0;
    chk(S_STATE, 2, "step_wait_state"); chk(S_PIPE, 0, "step_wait_pipe_en");
    chk(S_BUSY, 1, "step_wait_busy"); chk(S_CCNT, 0, "step_cnt_cleared");
    for (int k = 0; k < 3; k++) begin
      i_step = 1'b1;
      chk(S_PC, 0, "step_wait_pc_en");
      tick(); i_step = (k == 0);
      chk(S_STATE, 3, "step_exec_state"); chk(S_PC, 1, "step_exec_pc_en"); chk(S_PIPE, 1, "step_exec_pipe_en");
      tick(); i_step = 1'b0;
      chk(S_STATE, 2, "step_back_to_wait"); chk(S_CCNT, k + 1, "step_cycle_cnt");
      tick(); tick();
    end
    chk(S_CCNT, 3, "step_total_cycles"); chk(S_FCNT, 3, "step_total_fetches");

    // Halt during a step, then reset in the second drain cycle
    i_step = 1'b1;
    tick(); i_step = 1'b0; i_halt_id = 1'b1;
    chk(S_STATE, 3, "step_halt_state"); chk(S_PC, 0, "step_halt_pc_en"); chk(S_IFF, 1, "step_halt_flush");
    tick(); i_halt_id = 1'b0;
    chk(S_STATE, 4, "step_drain_state");
    tick();
    i_rst = 1'b1;
    tick(); i_rst = 1'b0;
    chk(S_STATE, 0, "mid_drain_rst_state"); chk(S_PC, 0, "mid_rst_pc_en"); chk(S_PIPE, 0, "mid_rst_pipe_en");
    chk(S_IFID, 0, "mid_rst_if_id_en"); chk(S_IFF, 0, "mid_rst_if_id_flush"); chk(S_BUSY, 0, "mid_rst_busy");
    chk(S_DONE, 0, "mid_rst_done"); chk(S_CCNT, 0, "mid_rst_cycle_cnt"); chk(S_FCNT, 0, "mid_rst_fetch_cnt");

    // Fresh continuous start after reset; step in RUN is ignored
    i_mode = 1'b0; i_start = 1'b1;
    tick(); i_start = 1'b0; i_step = 1'b1;
    chk(S_STATE, 1, "post_rst_run_state"); chk(S_PC, 1, "post_rst_pc_en");
    tick(); i_step = 1'b0;
    chk(S_STATE, 1, "run_step_ignored"); chk(S_CCNT, 1, "post_rst_cycle_cnt");

    tick(); tick();
    if (sb_q.size() != 0) begin
      $display("FAIL scoreboard: %0d expectations never checked", sb_q.size());
      n_total += sb_q.size();
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
